// File: rtl/cc_psr_unit_pkg.sv
// Shared types and helpers for the LC-3 condition-code unit: the one-hot
// N/Z/P record, its reset value, value classification and branch evaluation.
package cc_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_RESET = 3'b010;

  // The caller reduces its DATA_WIDTH-wide value to "is zero" and "sign bit",
  // so one function serves any data width.
  function automatic cc_t cc_classify(input logic is_zero, input logic sign_bit);
    cc_t c;
    c = '0;
    if (is_zero)       c.z = 1'b1;
    else if (sign_bit) c.n = 1'b1;
    else               c.p = 1'b1;
    return c;
  endfunction

  function automatic logic ben_eval(input logic [2:0] mask, input cc_t cc);
    return |(mask & cc);
  endfunction

endpackage

// File: rtl/cc_psr_unit_if.sv
// Bus between the datapath/control FSM and the condition-code unit.
// Controls are single-cycle level strobes sampled on each rising clock edge;
// there is no back-pressure, so a strobe is acted on (or flagged) in that edge.
interface cc_psr_unit_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
);
  localparam int CNT_WIDTH = $clog2(STACK_DEPTH + 1);

  logic [DATA_WIDTH-1:0] Data;
  logic                  LD_CC;
  logic                  LD_BEN;
  logic [2:0]            IR_nzp;
  logic                  CC_PUSH;
  logic                  CC_POP;
  logic                  clr_err;
  logic                  n;
  logic                  z;
  logic                  p;
  logic                  BEN;
  logic [CNT_WIDTH-1:0]  stack_count;
  logic                  stack_empty;
  logic                  stack_full;
  logic                  ovf_err;
  logic                  unf_err;

  modport master (
    output Data, LD_CC, LD_BEN, IR_nzp, CC_PUSH, CC_POP, clr_err,
    input  n, z, p, BEN, stack_count, stack_empty, stack_full, ovf_err, unf_err
  );

  modport slave (
    input  Data, LD_CC, LD_BEN, IR_nzp, CC_PUSH, CC_POP, clr_err,
    output n, z, p, BEN, stack_count, stack_empty, stack_full, ovf_err, unf_err
  );

endinterface

// File: rtl/cc_psr_unit_stack.sv
// Saturating LIFO of saved condition codes. Illegal requests (push when full,
// pop when empty, or both at once) leave it untouched and raise error pulses.
module cc_stack
  import cc_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  cc_t                  din,
  output cc_t                  dout,
  output logic                 pop_ok,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf_pulse,
  output logic                 unf_pulse
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cc_t                  mem [DEPTH];
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] top_cnt;
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        rd_idx;
  logic                 push_ok;

  assign full      = (count_q == CNT_WIDTH'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push & ~pop & ~full;
  assign pop_ok    = pop & ~push & ~empty;
  assign ovf_pulse = push & (pop | full);
  assign unf_pulse = pop & (push | empty);

  assign top_cnt = count_q - CNT_WIDTH'(1);
  assign wr_idx  = count_q[AW-1:0];
  assign rd_idx  = top_cnt[AW-1:0];
  assign dout    = mem[rd_idx];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count_q <= '0;
    else if (push_ok) count_q <= count_q + CNT_WIDTH'(1);
    else if (pop_ok)  count_q <= top_cnt;
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/cc_psr_unit.sv
// Condition-code unit: N/Z/P register, branch-enable register, sticky stack
// error flags, and the saved-CC stack used on interrupt entry and RTI.
module cc_psr_unit
  import cc_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
) (
  input logic           Clk,
  input logic           Reset,
  cc_psr_unit_if.slave  bus
);
  localparam int CNT_WIDTH = $clog2(STACK_DEPTH + 1);

  cc_t                  cc_q;
  cc_t                  stk_dout;
  cc_t                  cc_load;
  logic                 ben_q;
  logic                 ovf_q;
  logic                 unf_q;
  logic                 pop_ok;
  logic                 ovf_pulse;
  logic                 unf_pulse;
  logic                 full;
  logic                 empty;
  logic [CNT_WIDTH-1:0] count;

  assign cc_load = cc_classify(bus.Data == '0, bus.Data[DATA_WIDTH-1]);

  cc_stack #(
    .DEPTH     (STACK_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stack (
    .clk       (Clk),
    .rst       (Reset),
    .push      (bus.CC_PUSH),
    .pop       (bus.CC_POP),
    .din       (cc_q),
    .dout      (stk_dout),
    .pop_ok    (pop_ok),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf_pulse (ovf_pulse),
    .unf_pulse (unf_pulse)
  );

  // A successful pop restores the saved codes and overrides LD_CC; a failed
  // pop does not, so LD_CC still lands in that case.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cc_q  <= CC_RESET;
      ben_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (pop_ok)          cc_q <= stk_dout;
      else if (bus.LD_CC)  cc_q <= cc_load;
      if (bus.LD_BEN)      ben_q <= ben_eval(bus.IR_nzp, cc_q);
      if (ovf_pulse)       ovf_q <= 1'b1;
      else if (bus.clr_err) ovf_q <= 1'b0;
      if (unf_pulse)       unf_q <= 1'b1;
      else if (bus.clr_err) unf_q <= 1'b0;
    end
  end

  assign bus.n           = cc_q.n;
  assign bus.z           = cc_q.z;
  assign bus.p           = cc_q.p;
  assign bus.BEN         = ben_q;
  assign bus.stack_count = count;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;

endmodule

// File: tb/tb_cc_psr_unit.sv
// Directed and randomized checks of cc_psr_unit against a queue-based model
// of the condition-code register, branch enable and saved-CC stack.
module tb_cc_psr_unit;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  // Reference model state
  logic [2:0] m_cc;
  logic       m_ben;
  logic       m_ovf;
  logic       m_unf;
  logic [2:0] m_stack[$];

  cc_psr_unit_if #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) bus ();

  cc_psr_unit #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [2:0] classify(input logic [DW-1:0] d);
    if (d == 0)              return 3'b010;
    else if ($signed(d) < 0) return 3'b100;
    else                     return 3'b001;
  endfunction

  function automatic void model_reset();
    m_cc  = 3'b010;
    m_ben = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_stack.delete();
  endfunction

  // One clock edge worth of architectural behaviour, from the pre-edge state.
  function automatic void model_step(input logic [DW-1:0] d, input logic ldcc,
                                     input logic ldben, input logic [2:0] ir,
                                     input logic push, input logic pop,
                                     input logic clr);
    logic [2:0] old_cc;
    logic [2:0] new_cc;
    logic       o_set;
    logic       u_set;
    old_cc = m_cc;
    new_cc = m_cc;
    o_set  = 1'b0;
    u_set  = 1'b0;
    if (push && pop) begin
      o_set = 1'b1;
      u_set = 1'b1;
      if (ldcc) new_cc = classify(d);
    end else if (push) begin
      if (m_stack.size() == DEPTH) o_set = 1'b1;
      else m_stack.push_back(old_cc);
      if (ldcc) new_cc = classify(d);
    end else if (pop) begin
      if (m_stack.size() == 0) begin
        u_set = 1'b1;
        if (ldcc) new_cc = classify(d);
      end else begin
        new_cc = m_stack.pop_back();
      end
    end else if (ldcc) begin
      new_cc = classify(d);
    end
    if (ldben) m_ben = ((ir & old_cc) != 3'b000);
    m_ovf = o_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = u_set ? 1'b1 : (clr ? 1'b0 : m_unf);
    m_cc  = new_cc;
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".nzp"},   8'({bus.n, bus.z, bus.p}), 8'(m_cc));
    chk({tag, ".ben"},   8'(bus.BEN), 8'(m_ben));
    chk({tag, ".count"}, 8'(bus.stack_count), 8'(m_stack.size()));
    chk({tag, ".empty"}, 8'(bus.stack_empty), 8'(m_stack.size() == 0));
    chk({tag, ".full"},  8'(bus.stack_full), 8'(m_stack.size() == DEPTH));
    chk({tag, ".ovf"},   8'(bus.ovf_err), 8'(m_ovf));
    chk({tag, ".unf"},   8'(bus.unf_err), 8'(m_unf));
  endtask

  // Driver: present inputs, take one edge, update model, check after the edge.
  task automatic cycle(input string tag, input logic [DW-1:0] d, input logic ldcc,
                       input logic ldben, input logic [2:0] ir, input logic push,
                       input logic pop, input logic clr);
    bus.Data    = d;
    bus.LD_CC   = ldcc;
    bus.LD_BEN  = ldben;
    bus.IR_nzp  = ir;
    bus.CC_PUSH = push;
    bus.CC_POP  = pop;
    bus.clr_err = clr;
    @(posedge Clk);
    model_step(d, ldcc, ldben, ir, push, pop, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    Reset       = 1'b1;
    bus.Data    = '0;
    bus.LD_CC   = 1'b0;
    bus.LD_BEN  = 1'b0;
    bus.IR_nzp  = 3'b000;
    bus.CC_PUSH = 1'b0;
    bus.CC_POP  = 1'b0;
    bus.clr_err = 1'b0;
    repeat (2) @(negedge Clk);
    check_all("reset");
    Reset = 1'b0;

    // Classification, one cycle after each load
    cycle("ld_8000", 16'h8000, 1, 0, 3'b000, 0, 0, 0);
    chk("nzp_8000", 8'({bus.n, bus.z, bus.p}), 8'b100);
    cycle("ld_0000", 16'h0000, 1, 0, 3'b000, 0, 0, 0);
    chk("nzp_0000", 8'({bus.n, bus.z, bus.p}), 8'b010);
    cycle("ld_0001", 16'h0001, 1, 0, 3'b000, 0, 0, 0);
    chk("nzp_0001", 8'({bus.n, bus.z, bus.p}), 8'b001);

    // BEN samples the old codes when LD_CC shares the edge
    cycle("ben_old", 16'h0000, 1, 1, 3'b010, 0, 0, 0);
    chk("ben_old_lit", 8'(bus.BEN), 8'd0);
    cycle("ben_new", 16'h1234, 0, 1, 3'b010, 0, 0, 0);
    chk("ben_new_lit", 8'(bus.BEN), 8'd1);

    // Fill the stack with 100, 001, 010, 100, then overflow
    cycle("pre_100", 16'h8000, 1, 0, 3'b000, 0, 0, 0);
    cycle("push1",   16'h0001, 1, 0, 3'b000, 1, 0, 0);
    cycle("push2",   16'h0000, 1, 0, 3'b000, 1, 0, 0);
    cycle("push3",   16'h8000, 1, 0, 3'b000, 1, 0, 0);
    cycle("push4",   16'h0000, 0, 0, 3'b000, 1, 0, 0);
    cycle("push5",   16'h0000, 0, 0, 3'b000, 1, 0, 0);
    chk("ovf_full_lit", 8'({bus.stack_full, bus.ovf_err, 3'(bus.stack_count)}), 8'b11_100);
    cycle("pop1", 16'h0000, 0, 0, 3'b000, 0, 1, 0);
    chk("pop1_lit", 8'({bus.n, bus.z, bus.p}), 8'b100);
    cycle("pop2", 16'h0000, 0, 0, 3'b000, 0, 1, 0);
    chk("pop2_lit", 8'({bus.n, bus.z, bus.p}), 8'b010);
    cycle("pop3", 16'h0000, 1, 0, 3'b000, 0, 1, 0);
    chk("pop3_lit", 8'({bus.n, bus.z, bus.p}), 8'b001);
    cycle("pop4", 16'h0000, 0, 0, 3'b000, 0, 1, 0);
    chk("pop4_lit", 8'({bus.n, bus.z, bus.p, bus.stack_empty}), 8'b1001);

    // Underflow with LD_CC still honoured, then clear
    cycle("unf",     16'hFFFF, 1, 0, 3'b000, 0, 1, 0);
    chk("unf_lit", 8'({bus.unf_err, bus.n, bus.z, bus.p}), 8'b1100);
    cycle("clr",     16'h0000, 0, 0, 3'b000, 0, 0, 1);
    chk("clr_lit", 8'({bus.ovf_err, bus.unf_err}), 8'b00);

    // Simultaneous push/pop at count 2, then push with LD_CC
    cycle("fill_a",  16'h0000, 0, 0, 3'b000, 1, 0, 0);
    cycle("fill_b",  16'h0000, 0, 0, 3'b000, 1, 0, 0);
    cycle("pushpop", 16'h0005, 1, 0, 3'b000, 1, 1, 0);
    chk("pushpop_lit", 8'({bus.ovf_err, bus.unf_err, 3'(bus.stack_count)}), 8'b11_010);
    cycle("clr_set", 16'h0001, 0, 0, 3'b000, 1, 0, 1);
    cycle("clr_pri", 16'h0000, 0, 0, 3'b000, 0, 0, 1);
    cycle("set_p",   16'h0001, 1, 0, 3'b000, 0, 0, 0);
    cycle("push_ld", 16'h0000, 1, 0, 3'b000, 1, 0, 0);
    chk("push_ld_lit", 8'({bus.n, bus.z, bus.p}), 8'b010);
    cycle("pop_top", 16'h0000, 0, 0, 3'b000, 0, 1, 0);
    chk("pop_top_lit", 8'({bus.n, bus.z, bus.p}), 8'b001);

    // Asynchronous reset mid-cycle with count 3 and BEN 1
    cycle("ben_set", 16'h0000, 0, 1, 3'b111, 0, 0, 0);
    chk("pre_rst_lit", 8'({bus.BEN, 3'(bus.stack_count)}), 8'b1_011);
    #3;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    @(negedge Clk);
    Reset = 1'b0;
    cycle("post_push", 16'h8000, 1, 0, 3'b000, 1, 0, 0);
    cycle("post_pop",  16'h0000, 0, 0, 3'b000, 0, 1, 0);
    chk("post_pop_lit", 8'({bus.n, bus.z, bus.p, bus.stack_empty}), 8'b0101);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      cycle("rand", d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_psr_unit.md
Name: cc_psr_unit

Overview:
- Parametrised condition-code unit for the LC-3 datapath.
- Holds the one-hot N/Z/P register, loaded synchronously from the bus value.
- Computes the registered branch-enable bit BEN from IR[11:9].
- Keeps a LIFO of saved condition codes so interrupt entry can push, and RTI can pop, the CC field of the PSR. Overflow and underflow are flagged by sticky error bits.
- Sits between the bus/ALU output and the control FSM.

Parameters:
- DATA_WIDTH, 16, width of the value classified into N/Z/P
- STACK_DEPTH, 4, number of saved CC entries (must be >= 1)
- CNT_WIDTH, $clog2(STACK_DEPTH+1), width of stack_count (derived, not overridden)

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Data  in  DATA_WIDTH  value to classify (bus output)
- LD_CC  in  1  load N/Z/P from Data this cycle
- LD_BEN  in  1  load BEN this cycle
- IR_nzp  in  3  IR[11:9] branch condition mask {n,z,p}
- CC_PUSH  in  1  save current N/Z/P onto stack
- CC_POP  in  1  restore N/Z/P from top of stack
- clr_err  in  1  clear sticky error flags
- n, z, p  out  1 each  registered condition codes
- BEN  out  1  registered branch enable
- stack_count  out  CNT_WIDTH  entries currently saved
- stack_empty  out  1  stack_count == 0
- stack_full  out  1  stack_count == STACK_DEPTH
- ovf_err  out  1  sticky: push attempted while full
- unf_err  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, any time, including mid-operation):
  - {n,z,p} = 3'b010 and BEN = 0.
  - stack_count = 0, stack_empty = 1, stack_full = 0.
  - ovf_err = unf_err = 0.
  - Stack contents are don't-care.
- Classification of Data:
  - z when Data == 0.
  - Otherwise n when Data[DATA_WIDTH-1] == 1.
  - Otherwise p.
- Invariant: {n,z,p} is always one-hot.
- LD_CC: {n,z,p} takes the classification of Data at the edge. Visible the cycle after the edge; latency 1.
- LD_BEN:
  - BEN <= |(IR_nzp & {n,z,p}), using the pre-edge register value.
  - With LD_CC in the same cycle, BEN uses the OLD codes.
  - BEN holds when LD_BEN is low.
- CC_PUSH (not full, no POP): writes the pre-edge {n,z,p} to entry stack_count, then stack_count + 1.
- CC_PUSH with LD_CC in the same cycle: the old codes are pushed and the new codes are loaded. Both actions take effect.
- CC_POP (not empty, no PUSH): {n,z,p} <= entry stack_count-1, then stack_count - 1.
- CC_POP with LD_CC in the same cycle: POP wins and LD_CC is ignored.
- PUSH while full: stack and codes unchanged; ovf_err <= 1. An LD_CC in the same cycle is still honoured.
- POP while empty: stack and codes unchanged; unf_err <= 1. An LD_CC in the same cycle is still honoured.
- PUSH and POP in the same cycle: illegal.
  - Stack unchanged.
  - Codes follow LD_CC if asserted.
  - ovf_err <= 1 and unf_err <= 1.
- clr_err clears both error flags. An error detected in the same cycle takes priority, so that flag is set.
- stack_full and stack_empty are decoded combinationally from the registered stack_count. They never glitch outside Clk edges.
- No internal state machine beyond the counter. The stack pointer never wraps; it saturates at 0 and STACK_DEPTH.

Decomposition:
- Package cc_pkg:
  - typedef cc_t (packed struct n,z,p)
  - constant CC_RESET = 3'b010
  - function cc_classify(Data) returning cc_t, parametrised via DATA_WIDTH in the caller
  - function ben_eval(mask, cc)
- Sub-module cc_stack:
  - parametrised LIFO of cc_t, depth STACK_DEPTH.
  - push/pop/din/dout, count, full, empty, and error pulses.
  - Top level owns the CC and BEN registers and the sticky flags.

Test Plan:
- Reset then LD_CC with Data=16'h8000, then 16'h0000, then 16'h0001 → nzp reads 100, 010, 001, each one cycle after the load.
- Set nzp=001 and drive LD_BEN with IR_nzp=3'b010 and also LD_CC with Data=16'h0000 in the same cycle → BEN=0, because it uses the old p; a following LD_BEN with 3'b010 → BEN=1.
- STACK_DEPTH=4: push with codes 100, 001, 010, 100; a fifth push → stack_full=1, ovf_err=1, count stays 4. Then 4 pops → codes restore 100, 010, 001, 100 in order, and stack_empty=1.
- Pop while empty with LD_CC Data=16'hFFFF → unf_err=1, nzp=100; clr_err next cycle → unf_err=0.
- PUSH and POP together with count=2 → count stays 2, both error flags set; PUSH and LD_CC together (Data=0, prior p) → top entry=001, nzp=010.
- Assert Reset asynchronously mid-cycle with count=3, BEN=1 → all outputs take their reset values immediately; the first push after release writes entry 0.
